// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: ICCM fetch front end with prefetch FIFO, redirect squash and loader/BIST port muxing.
// Defining FETCH_PERF_CNT_EN adds the perf_stall_cnt/perf_flush_cnt counters.
module fetch_prefetch_unit #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_addr,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [DATA_WIDTH-1:0] inst_data,
   output logic [ADDR_WIDTH-1:0] inst_pc,
   input  logic                  cntlr_wr,
   input  logic [ADDR_WIDTH-1:0] cntlr_waddr,
   input  logic [DATA_WIDTH-1:0] cntlr_wr_data,
   input  logic                  bist_en,
   input  logic                  bist_rd,
   input  logic [ADDR_WIDTH-1:0] bist_raddr,
   input  logic                  bist_wr,
   input  logic [ADDR_WIDTH-1:0] bist_waddr,
   input  logic [DATA_WIDTH-1:0] bist_wr_data,
   output logic [DATA_WIDTH-1:0] bist_rd_data,
   output logic                  bist_rd_valid,
   output logic                  mem_rd,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  mem_wr,
   output logic [ADDR_WIDTH-1:0] mem_wr_addr,
`ifdef FETCH_PERF_CNT_EN
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   output logic [31:0]           perf_stall_cnt,
   output logic [15:0]           perf_flush_cnt
`else
   output logic [DATA_WIDTH-1:0] mem_wr_data
`endif
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);
   localparam logic [1:0] S_BOOT = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_BIST = 2'd2;
   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] inflight_pc;
   logic                  inflight;
   logic                  inflight_epoch;
   logic                  epoch;
   logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_pc [FIFO_DEPTH];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [PW:0]           count;
   logic                  run;
   logic                  bist;
   logic                  redirect;
   logic                  flush;
   logic                  issue;
   logic                  push;
   logic                  pop;
   assign run      = state == S_RUN;
   assign bist     = state == S_BIST;
   assign redirect = run & redirect_valid;
   assign flush    = redirect | bist_en;
   // Credit counts the in-flight read so a returning word always has a free slot
   assign issue    = run & ~cntlr_wr & ~redirect_valid & ((count + {{PW{1'b0}}, inflight}) < DEPTH);
   // Epoch tag squashes a read that was issued before the most recent redirect
   assign push     = run & inflight & (inflight_epoch == epoch) & ~flush;
   assign inst_valid = run & (count != '0);
   assign pop      = inst_valid & inst_ready & ~flush;
   assign inst_data = fifo_data[rd_ptr];
   assign inst_pc   = fifo_pc[rd_ptr];
   assign bist_rd_data = mem_rd_data;
   always_comb begin
      mem_rd      = bist ? bist_rd : issue;
      mem_rd_addr = bist ? bist_raddr : pc;
      mem_wr      = bist ? bist_wr : cntlr_wr;
      mem_wr_addr = bist ? bist_waddr : cntlr_waddr;
      mem_wr_data = bist ? bist_wr_data : cntlr_wr_data;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= S_BOOT;
         pc             <= RESET_PC;
         inflight       <= 1'b0;
         inflight_epoch <= 1'b0;
         inflight_pc    <= RESET_PC;
         epoch          <= 1'b0;
         bist_rd_valid  <= 1'b0;
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         count          <= '0;
      end else begin
         state          <= bist_en ? S_BIST : (bist ? S_BOOT : S_RUN);
         pc             <= bist ? RESET_PC : redirect ? redirect_addr : issue ? pc + 1'b1 : pc;
         inflight       <= issue;
         inflight_epoch <= epoch;
         inflight_pc    <= pc;
         epoch          <= epoch ^ redirect;
         bist_rd_valid  <= bist_rd;
         rd_ptr         <= flush ? '0 : rd_ptr + PW'(pop);
         wr_ptr         <= flush ? '0 : wr_ptr + PW'(push);
         count          <= flush ? '0 : count + (PW+1)'(push) - (PW+1)'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= mem_rd_data;
         fifo_pc[wr_ptr]   <= inflight_pc;
      end
   end
   always_ff @(posedge clk) begin
      if (rst_n && push) assert (count != DEPTH);
   end
`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (run & inst_ready & ~inst_valid & ~&perf_stall_cnt) perf_stall_cnt <= perf_stall_cnt + 1'b1;
         if (redirect & ~&perf_flush_cnt) perf_flush_cnt <= perf_flush_cnt + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: vector table, corner sequences and random traffic against a PC-stream model.
module tb_fetch_prefetch_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [10:0] redirect_addr = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b1;
   logic [31:0] inst_data;
   logic [10:0] inst_pc;
   logic        cntlr_wr = 1'b0;
   logic [10:0] cntlr_waddr = '0;
   logic [31:0] cntlr_wr_data = '0;
   logic        bist_en = 1'b0;
   logic        bist_rd = 1'b0;
   logic [10:0] bist_raddr = '0;
   logic        bist_wr = 1'b0;
   logic [10:0] bist_waddr = '0;
   logic [31:0] bist_wr_data = '0;
   logic [31:0] bist_rd_data;
   logic        bist_rd_valid;
   logic        mem_rd;
   logic [10:0] mem_rd_addr;
   logic [31:0] mem_rd_data = '0;
   logic        mem_wr;
   logic [10:0] mem_wr_addr;
   logic [31:0] mem_wr_data;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_stall_cnt;
   logic [15:0] perf_flush_cnt;
`endif
   fetch_prefetch_unit dut (
      .clk(clk), .rst_n(rst_n),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
      .cntlr_wr(cntlr_wr), .cntlr_waddr(cntlr_waddr), .cntlr_wr_data(cntlr_wr_data),
      .bist_en(bist_en), .bist_rd(bist_rd), .bist_raddr(bist_raddr),
      .bist_wr(bist_wr), .bist_waddr(bist_waddr), .bist_wr_data(bist_wr_data),
      .bist_rd_data(bist_rd_data), .bist_rd_valid(bist_rd_valid),
      .mem_rd(mem_rd), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .mem_wr(mem_wr), .mem_wr_addr(mem_wr_addr),
`ifdef FETCH_PERF_CNT_EN
      .mem_wr_data(mem_wr_data), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`else
      .mem_wr_data(mem_wr_data)
`endif
   );
   always #5 clk = ~clk;
   logic [31:0] mem_arr [2048];
   always @(posedge clk) begin
      if (mem_rd) mem_rd_data <= mem_arr[mem_rd_addr];
      if (mem_wr) mem_arr[mem_wr_addr] <= mem_wr_data;
   end
   int n_chk = 0;
   int n_fail = 0;
   int n_acc = 0;
   logic [10:0] exp_pc = '0;
   logic [10:0] last_acc = '0;
   logic        wrap_seen = 1'b0;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask
   // Model: decode must see an unbroken PC sequence restarting at each redirect target or after reset/BIST
   always @(negedge clk) begin
      if (!rst_n || bist_en) exp_pc = 11'h000;
      else if (redirect_valid) exp_pc = redirect_addr;
      else if (inst_valid && inst_ready) begin
         check("acc_pc", {21'h0, inst_pc}, {21'h0, exp_pc});
         check("acc_data", inst_data, mem_arr[exp_pc]);
         if (exp_pc == 11'h000 && last_acc == 11'h7FF && inst_pc == 11'h000) wrap_seen = 1'b1;
         last_acc = exp_pc;
         exp_pc = exp_pc + 11'h1;
         n_acc++;
      end
      if (!bist_en && mem_wr) check("rd_wr_excl", {31'h0, mem_rd}, 32'h0);
   end
   typedef struct {
      logic        rdy;
      logic        redir;
      logic [10:0] raddr;
      logic        ev;
      logic [10:0] epc;
      logic        erd;
      logic [10:0] eaddr;
   } vec_t;
   vec_t tbl [16];
   int lat;
   int acc0;
   initial begin
      for (int i = 0; i < 2048; i++) mem_arr[i] = 32'h100 + i;
      tbl[0]  = '{1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 11'h000};
      tbl[1]  = '{1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 11'h000};
      tbl[2]  = '{1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 11'h001};
      tbl[3]  = '{1'b1, 1'b0, 11'h000, 1'b1, 11'h000, 1'b1, 11'h002};
      tbl[4]  = '{1'b1, 1'b0, 11'h000, 1'b1, 11'h001, 1'b1, 11'h003};
      tbl[5]  = '{1'b1, 1'b1, 11'h7F0, 1'b1, 11'h002, 1'b0, 11'h000};
      tbl[6]  = '{1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 11'h7F0};
      tbl[7]  = '{1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 11'h7F1};
      tbl[8]  = '{1'b1, 1'b0, 11'h000, 1'b1, 11'h7F0, 1'b1, 11'h7F2};
      tbl[9]  = '{1'b0, 1'b0, 11'h000, 1'b1, 11'h7F1, 1'b1, 11'h7F3};
      tbl[10] = '{1'b0, 1'b0, 11'h000, 1'b1, 11'h7F1, 1'b1, 11'h7F4};
      tbl[11] = '{1'b0, 1'b0, 11'h000, 1'b1, 11'h7F1, 1'b0, 11'h000};
      tbl[12] = '{1'b0, 1'b0, 11'h000, 1'b1, 11'h7F1, 1'b0, 11'h000};
      tbl[13] = '{1'b1, 1'b0, 11'h000, 1'b1, 11'h7F1, 1'b0, 11'h000};
      tbl[14] = '{1'b1, 1'b0, 11'h000, 1'b1, 11'h7F2, 1'b1, 11'h7F5};
      tbl[15] = '{1'b1, 1'b0, 11'h000, 1'b1, 11'h7F3, 1'b1, 11'h7F6};
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
      check("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
      check("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
      check("rst_bist_rd_valid", {31'h0, bist_rd_valid}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      // Boot latency, redirect latency and back-pressure, cycle by cycle
      for (int i = 0; i < 16; i++) begin
         inst_ready = tbl[i].rdy;
         redirect_valid = tbl[i].redir;
         redirect_addr = tbl[i].raddr;
         @(negedge clk);
         check($sformatf("vec%0d_valid", i), {31'h0, inst_valid}, {31'h0, tbl[i].ev});
         if (tbl[i].ev) check($sformatf("vec%0d_pc", i), {21'h0, inst_pc}, {21'h0, tbl[i].epc});
         check($sformatf("vec%0d_mem_rd", i), {31'h0, mem_rd}, {31'h0, tbl[i].erd});
         if (tbl[i].erd) check($sformatf("vec%0d_rd_addr", i), {21'h0, mem_rd_addr}, {21'h0, tbl[i].eaddr});
         @(posedge clk); #1;
      end
`ifdef FETCH_PERF_CNT_EN
      check("perf_stall", perf_stall_cnt, 32'd4);
      check("perf_flush", {16'h0, perf_flush_cnt}, 32'd1);
`endif
      inst_ready = 1'b1;
      // Loader writes every other cycle: port must go to the write, fetch keeps order
      for (int i = 0; i < 20; i++) begin
         cntlr_wr = i[0];
         cntlr_waddr = 11'd5;
         cntlr_wr_data = 32'h105;
         @(negedge clk);
         if (cntlr_wr) begin
            check("ldr_mem_wr", {31'h0, mem_wr}, 32'h1);
            check("ldr_no_rd", {31'h0, mem_rd}, 32'h0);
            check("ldr_waddr", {21'h0, mem_wr_addr}, 32'd5);
         end
         @(posedge clk); #1;
      end
      cntlr_wr = 1'b0;
      wrap_seen = 1'b0;
      redirect_valid = 1'b1;
      redirect_addr = 11'h7F0;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      repeat (25) @(posedge clk);
      #1;
      check("pc_wrap_seen", {31'h0, wrap_seen}, 32'h1);
      bist_en = 1'b1;
      @(posedge clk); #1;
      bist_rd = 1'b1;
      bist_raddr = 11'd3;
      bist_wr = 1'b1;
      bist_waddr = 11'd9;
      bist_wr_data = 32'hCAFE_0009;
      @(negedge clk);
      check("bist_inst_valid", {31'h0, inst_valid}, 32'h0);
      check("bist_mem_rd", {31'h0, mem_rd}, 32'h1);
      check("bist_rd_addr", {21'h0, mem_rd_addr}, 32'd3);
      check("bist_mem_wr", {31'h0, mem_wr}, 32'h1);
      check("bist_wr_addr", {21'h0, mem_wr_addr}, 32'd9);
      check("bist_wr_data", mem_wr_data, 32'hCAFE_0009);
      @(posedge clk); #1;
      bist_rd = 1'b0;
      bist_wr = 1'b0;
      @(negedge clk);
      check("bist_rd_valid", {31'h0, bist_rd_valid}, 32'h1);
      check("bist_rd_data", bist_rd_data, 32'h103);
      @(posedge clk); #1;
      bist_en = 1'b0;
      lat = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (inst_valid) begin
            lat = k;
            break;
         end
         @(posedge clk); #1;
      end
      check("bist_exit_latency", lat, 32'd4);
      if (lat >= 0) begin
         check("bist_exit_pc", {21'h0, inst_pc}, 32'h0);
         @(posedge clk); #1;
      end
      repeat (15) @(posedge clk);
      #1;
      acc0 = n_acc;
      // Random decode stalls, redirects and loader traffic
      for (int i = 0; i < 400; i++) begin
         inst_ready = $urandom_range(0, 3) != 0;
         redirect_valid = $urandom_range(0, 19) == 0;
         redirect_addr = $urandom_range(0, 1) != 0 ? 11'($urandom_range(0, 2047)) : 11'(11'h7F8 + $urandom_range(0, 7));
         cntlr_wr = $urandom_range(0, 9) == 0;
         cntlr_waddr = 11'($urandom_range(0, 2047));
         cntlr_wr_data = mem_arr[cntlr_waddr];
         @(posedge clk); #1;
      end
      redirect_valid = 1'b0;
      cntlr_wr = 1'b0;
      inst_ready = 1'b1;
      check("rand_progress", {31'h0, (n_acc - acc0) >= 150}, 32'h1);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_inst_valid", {31'h0, inst_valid}, 32'h0);
      check("midrst_mem_rd", {31'h0, mem_rd}, 32'h0);
      check("midrst_bist_rd_valid", {31'h0, bist_rd_valid}, 32'h0);
      @(posedge clk); #1;
      acc0 = n_acc;
      repeat (20) @(posedge clk);
      #1;
      check("midrst_progress", {31'h0, (n_acc - acc0) >= 15}, 32'h1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
